// File: rtl/disp_scan.sv
// Four-digit time-multiplexed 7-segment scanner feeding an MC14495-style decoder.
// Optional leading-zero suppression is enabled with `define LEADING_ZERO_BLANK_EN.
module disp_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
    output logic [3:0]  AN,
    output logic [3:0]  HEX,
    output logic        point,
    output logic        LE
);

    // sel | meaning
    //  0  | digit 0 (rightmost) slot
    //  1  | digit 1 slot
    //  2  | digit 2 slot
    //  3  | digit 3 slot, its wrap reloads the snapshot
    localparam logic [1:0] SEL_LAST = 2'd3;

    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [BW-1:0]    BLANK_INIT = BW'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
    logic             load_pending_q, load_pending_d;

    logic [15:0]      snap_hex_q, snap_hex_d;
    logic [3:0]       snap_points_q, snap_points_d;
    logic [3:0]       snap_les_q, snap_les_d;

    logic [3:0]       an_q, an_d;
    logic [3:0]       hex_q, hex_d;
    logic             point_q, point_d;
    logic             le_q, le_d;

    logic             wrap;
    logic             load;
    logic [3:0]       suppress;
    logic [3:0]       digit;

    always_comb begin
        wrap        = (div_cnt_q == DIV_LAST);
        div_cnt_d   = wrap ? '0 : div_cnt_q + 1'b1;
        sel_d       = wrap ? sel_q + 2'd1 : sel_q;
        blank_cnt_d = blank_cnt_q;
        if (wrap) begin
            blank_cnt_d = BLANK_INIT;
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - 1'b1;
        end

        load           = load_pending_q | (wrap && (sel_q == SEL_LAST));
        load_pending_d = 1'b0;
        snap_hex_d     = load ? hexs   : snap_hex_q;
        snap_points_d  = load ? points : snap_points_q;
        snap_les_d     = load ? LEs    : snap_les_q;
    end

    // A digit is a leading zero only if it and every digit to its left is 0 with no dot.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        suppress    = 4'b0000;
        suppress[3] = (snap_hex_d[15:12] == 4'h0) && !snap_points_d[3];
        suppress[2] = suppress[3] && (snap_hex_d[11:8] == 4'h0) && !snap_points_d[2];
        suppress[1] = suppress[2] && (snap_hex_d[7:4] == 4'h0) && !snap_points_d[1];
    end
`else
    assign suppress = 4'b0000;
`endif

    // Outputs are decoded from next-state values so they land on the same edge as sel/blank_cnt.
    always_comb begin
        digit = snap_hex_d[{sel_d, 2'b00} +: 4];
        hex_d = digit;
        if (blank_cnt_d != '0) begin
            an_d    = 4'b1111;
            point_d = 1'b0;
            le_d    = 1'b1;
        end else begin
            an_d    = ~(4'b0001 << sel_d);
            point_d = snap_points_d[sel_d] & ~suppress[sel_d];
            le_d    = snap_les_d[sel_d] | suppress[sel_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q      <= '0;
            sel_q          <= 2'd0;
            blank_cnt_q    <= BLANK_INIT;
            load_pending_q <= 1'b1;
            snap_hex_q     <= 16'h0000;
            snap_points_q  <= 4'b0000;
            snap_les_q     <= 4'b1111;
            an_q           <= 4'b1111;
            hex_q          <= 4'h0;
            point_q        <= 1'b0;
            le_q           <= 1'b1;
        end else begin
            div_cnt_q      <= div_cnt_d;
            sel_q          <= sel_d;
            blank_cnt_q    <= blank_cnt_d;
            load_pending_q <= load_pending_d;
            snap_hex_q     <= snap_hex_d;
            snap_points_q  <= snap_points_d;
            snap_les_q     <= snap_les_d;
            an_q           <= an_d;
            hex_q          <= hex_d;
            point_q        <= point_d;
            le_q           <= le_d;
        end
    end

    assign AN    = an_q;
    assign HEX   = hex_q;
    assign point = point_q;
    assign LE    = le_q;

endmodule
